// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: read/write FSM state encodings and requester index constants for mem_port_arbiter
package mem_arb_pkg;
  localparam int NUM_MASTERS = 2;
  localparam int M0 = 0;
  localparam int M1 = 1;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_st_e;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP} wr_st_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side (m_*) and memory-side (s_*) AXI-lite-style channels plus grants; master = arbiter view, slave = environment view
interface mem_port_arbiter_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  import mem_arb_pkg::*;
  logic [NUM_MASTERS-1:0] m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready;
  logic [NUM_MASTERS-1:0] m_ar_ready, m_aw_ready, m_w_ready, m_r_valid, m_b_valid;
  logic [NUM_MASTERS*ADDR_WDTH-1:0] m_ar_addr, m_aw_addr;
  logic [NUM_MASTERS*DATA_WDTH-1:0] m_w_data;
  logic [DATA_WDTH-1:0] m_r_data, s_w_data, s_r_data;
  logic [RESP_WDTH-1:0] m_r_resp, m_b_resp, s_r_resp, s_b_resp;
  logic s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready;
  logic s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid;
  logic [ADDR_WDTH-1:0] s_ar_addr, s_aw_addr;
  logic [NUM_MASTERS-1:0] rd_grant, wr_grant;
  modport master (
    input  m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready, m_ar_addr, m_aw_addr, m_w_data,
    input  s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid, s_r_data, s_r_resp, s_b_resp,
    output m_ar_ready, m_aw_ready, m_w_ready, m_r_valid, m_b_valid, m_r_data, m_r_resp, m_b_resp,
    output s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready, s_ar_addr, s_aw_addr, s_w_data,
    output rd_grant, wr_grant
  );
  modport slave (
    output m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready, m_ar_addr, m_aw_addr, m_w_data,
    output s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid, s_r_data, s_r_resp, s_b_resp,
    input  m_ar_ready, m_aw_ready, m_w_ready, m_r_valid, m_b_valid, m_r_data, m_r_resp, m_b_resp,
    input  s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready, s_ar_addr, s_aw_addr, s_w_data,
    input  rd_grant, wr_grant
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-input round-robin picker (clk, rst, i_req, i_adv in; one-hot o_gnt out) with registered pointer
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_adv,
  output logic [NUM_MASTERS-1:0] o_gnt
);
  logic r_ptr;
  always_comb o_gnt = &i_req ? (r_ptr ? 2'b10 : 2'b01) : i_req;
  // Pointer moves when the grant is taken; it is only consulted again once the owner has completed.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= o_gnt[M0];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between M0/M1 with independent round-robin read and write FSMs (clk, rst, io_bus master modport)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master io_bus
);
  rd_st_e r_rd_st, w_rd_st_n;
  wr_st_e r_wr_st, w_wr_st_n;
  logic [NUM_MASTERS-1:0] r_rd_gnt, w_rd_gnt_n, w_rd_pick, r_wr_gnt, w_wr_gnt_n, w_wr_pick;
  logic r_aw_done, r_w_done, w_aw_done_n, w_w_done_n;
  logic w_rd_take, w_wr_take, w_aw_open, w_w_open;
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .i_req(io_bus.m_ar_valid), .i_adv(w_rd_take), .o_gnt(w_rd_pick));
  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .i_req(io_bus.m_aw_valid), .i_adv(w_wr_take), .o_gnt(w_wr_pick));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd_st   <= RD_IDLE;
      r_rd_gnt  <= '0;
      r_wr_st   <= WR_IDLE;
      r_wr_gnt  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_rd_st   <= w_rd_st_n;
      r_rd_gnt  <= w_rd_gnt_n;
      r_wr_st   <= w_wr_st_n;
      r_wr_gnt  <= w_wr_gnt_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
    end
  always_comb begin
    w_rd_take = r_rd_st == RD_IDLE && |io_bus.m_ar_valid;
    io_bus.s_ar_valid = r_rd_st == RD_ADDR && |(io_bus.m_ar_valid & r_rd_gnt);
    io_bus.s_ar_addr = r_rd_gnt[M1] ? io_bus.m_ar_addr[ADDR_WDTH +: ADDR_WDTH] : io_bus.m_ar_addr[0 +: ADDR_WDTH];
    io_bus.m_ar_ready = r_rd_st == RD_ADDR ? r_rd_gnt & {NUM_MASTERS{io_bus.s_ar_ready}} : '0;
    io_bus.m_r_valid = r_rd_st == RD_DATA ? r_rd_gnt & {NUM_MASTERS{io_bus.s_r_valid}} : '0;
    io_bus.s_r_ready = r_rd_st == RD_DATA && |(io_bus.m_r_ready & r_rd_gnt);
    io_bus.m_r_data = io_bus.s_r_data;
    io_bus.m_r_resp = io_bus.s_r_resp;
    io_bus.rd_grant = r_rd_gnt;
    w_rd_st_n = r_rd_st;
    w_rd_gnt_n = r_rd_gnt;
    if (w_rd_take) begin
      w_rd_st_n = RD_ADDR;
      w_rd_gnt_n = w_rd_pick;
    end else if (io_bus.s_ar_valid && io_bus.s_ar_ready) w_rd_st_n = RD_DATA;
    else if (io_bus.s_r_ready && io_bus.s_r_valid) begin
      w_rd_st_n = RD_IDLE;
      w_rd_gnt_n = '0;
    end
  end
  always_comb begin
    w_wr_take = r_wr_st == WR_IDLE && |io_bus.m_aw_valid;
    w_aw_open = r_wr_st == WR_REQ && !r_aw_done;
    w_w_open = r_wr_st == WR_REQ && !r_w_done;
    io_bus.s_aw_valid = w_aw_open && |(io_bus.m_aw_valid & r_wr_gnt);
    io_bus.s_w_valid = w_w_open && |(io_bus.m_w_valid & r_wr_gnt);
    io_bus.s_aw_addr = r_wr_gnt[M1] ? io_bus.m_aw_addr[ADDR_WDTH +: ADDR_WDTH] : io_bus.m_aw_addr[0 +: ADDR_WDTH];
    io_bus.s_w_data = r_wr_gnt[M1] ? io_bus.m_w_data[DATA_WDTH +: DATA_WDTH] : io_bus.m_w_data[0 +: DATA_WDTH];
    io_bus.m_aw_ready = w_aw_open ? r_wr_gnt & {NUM_MASTERS{io_bus.s_aw_ready}} : '0;
    io_bus.m_w_ready = w_w_open ? r_wr_gnt & {NUM_MASTERS{io_bus.s_w_ready}} : '0;
    io_bus.m_b_valid = r_wr_st == WR_RESP ? r_wr_gnt & {NUM_MASTERS{io_bus.s_b_valid}} : '0;
    io_bus.s_b_ready = r_wr_st == WR_RESP && |(io_bus.m_b_ready & r_wr_gnt);
    io_bus.m_b_resp = io_bus.s_b_resp;
    io_bus.wr_grant = r_wr_gnt;
    w_aw_done_n = r_aw_done | (io_bus.s_aw_valid & io_bus.s_aw_ready);
    w_w_done_n = r_w_done | (io_bus.s_w_valid & io_bus.s_w_ready);
    w_wr_st_n = r_wr_st;
    w_wr_gnt_n = r_wr_gnt;
    if (w_wr_take) begin
      w_wr_st_n = WR_REQ;
      w_wr_gnt_n = w_wr_pick;
    end else if (r_wr_st == WR_REQ && w_aw_done_n && w_w_done_n) w_wr_st_n = WR_RESP;
    else if (io_bus.s_b_ready && io_bus.s_b_valid) begin
      w_wr_st_n = WR_IDLE;
      w_wr_gnt_n = '0;
      w_aw_done_n = 1'b0;
      w_w_done_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven read vectors plus hand sequences for write ordering, concurrency and async reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) bus ();
  mem_port_arbiter #(.ADDR_WDTH(4), .DATA_WDTH(32)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  int errs = 0, checks = 0, aw_cnt = 0, w_cnt = 0, w0;
  logic [3:0] last_aw;
  logic [31:0] last_w;
  logic aw_got, w_got, aw_hs, w_hs;
  function automatic logic [31:0] rd_val(input logic [3:0] a);
    return a == 4'h9 ? 32'hDEADBEEF : 32'hC0DE0000 | 32'(a);
  endfunction
  function automatic logic [31:0] outs();
    return 32'({bus.rd_grant, bus.wr_grant, bus.s_ar_valid, bus.s_aw_valid, bus.s_w_valid, bus.s_r_ready,
                bus.s_b_ready, bus.m_ar_ready, bus.m_aw_ready, bus.m_w_ready, bus.m_r_valid, bus.m_b_valid});
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  assign aw_hs = bus.s_aw_valid & bus.s_aw_ready;
  assign w_hs = bus.s_w_valid & bus.s_w_ready;
  always @(posedge clk or posedge rst)
    if (rst) begin
      bus.s_r_valid <= 1'b0;
      bus.s_b_valid <= 1'b0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
    end else begin
      if (bus.s_ar_valid && bus.s_ar_ready) begin
        bus.s_r_valid <= 1'b1;
        bus.s_r_data <= rd_val(bus.s_ar_addr);
      end else if (bus.s_r_valid && bus.s_r_ready) bus.s_r_valid <= 1'b0;
      if (aw_hs) begin
        aw_cnt <= aw_cnt + 1;
        last_aw <= bus.s_aw_addr;
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 1;
        last_w <= bus.s_w_data;
      end
      if (bus.s_b_valid && bus.s_b_ready) bus.s_b_valid <= 1'b0;
      else if ((aw_got || aw_hs) && (w_got || w_hs) && !bus.s_b_valid) begin
        bus.s_b_valid <= 1'b1;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs) w_got <= 1'b1;
      end
    end
  typedef struct packed {
    logic [1:0] ar_v; logic [7:0] ar_a; logic [1:0] r_rdy;
    logic [1:0] gnt; logic s_arv; logic [3:0] s_ara; logic [1:0] ar_rdy; logic [1:0] r_v; logic s_rrdy; logic [31:0] r_d;
  } vec_t;
  vec_t tbl [21];
  initial begin
    rst = 1'b1;
    bus.m_ar_valid = '0; bus.m_aw_valid = '0; bus.m_w_valid = '0;
    bus.m_ar_addr = '0; bus.m_aw_addr = '0; bus.m_w_data = '0;
    bus.m_r_ready = 2'b11; bus.m_b_ready = 2'b11;
    bus.s_ar_ready = 1'b1; bus.s_aw_ready = 1'b1; bus.s_w_ready = 1'b1;
    bus.s_r_resp = '0; bus.s_b_resp = '0;
    tbl[0]  = '{2'b11, 8'h21, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{2'b11, 8'h21, 2'b11, 2'b01, 1'b1, 4'h1, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[2]  = '{2'b10, 8'h21, 2'b11, 2'b01, 1'b0, 4'h0, 2'b00, 2'b01, 1'b1, 32'hC0DE0001};
    tbl[3]  = '{2'b11, 8'h21, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[4]  = '{2'b11, 8'h21, 2'b11, 2'b10, 1'b1, 4'h2, 2'b10, 2'b00, 1'b0, 32'h0};
    tbl[5]  = '{2'b01, 8'h21, 2'b11, 2'b10, 1'b0, 4'h0, 2'b00, 2'b10, 1'b1, 32'hC0DE0002};
    tbl[6]  = '{2'b01, 8'h21, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[7]  = '{2'b01, 8'h21, 2'b11, 2'b01, 1'b1, 4'h1, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[8]  = '{2'b00, 8'h21, 2'b11, 2'b01, 1'b0, 4'h0, 2'b00, 2'b01, 1'b1, 32'hC0DE0001};
    tbl[9]  = '{2'b00, 8'h00, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[10] = '{2'b10, 8'h90, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[11] = '{2'b10, 8'h90, 2'b11, 2'b10, 1'b1, 4'h9, 2'b10, 2'b00, 1'b0, 32'h0};
    tbl[12] = '{2'b00, 8'h90, 2'b11, 2'b10, 1'b0, 4'h0, 2'b00, 2'b10, 1'b1, 32'hDEADBEEF};
    tbl[13] = '{2'b00, 8'h00, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[14] = '{2'b01, 8'h05, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[15] = '{2'b01, 8'h05, 2'b11, 2'b01, 1'b1, 4'h5, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[16] = '{2'b00, 8'h05, 2'b10, 2'b01, 1'b0, 4'h0, 2'b00, 2'b01, 1'b0, 32'hC0DE0005};
    tbl[17] = '{2'b00, 8'h05, 2'b10, 2'b01, 1'b0, 4'h0, 2'b00, 2'b01, 1'b0, 32'hC0DE0005};
    tbl[18] = '{2'b00, 8'h05, 2'b10, 2'b01, 1'b0, 4'h0, 2'b00, 2'b01, 1'b0, 32'hC0DE0005};
    tbl[19] = '{2'b00, 8'h05, 2'b11, 2'b01, 1'b0, 4'h0, 2'b00, 2'b01, 1'b1, 32'hC0DE0005};
    tbl[20] = '{2'b00, 8'h00, 2'b11, 2'b00, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 32'h0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("reset_outputs", outs(), 32'h0);
    for (int i = 0; i < 21; i++) begin
      bus.m_ar_valid = tbl[i].ar_v;
      bus.m_ar_addr = tbl[i].ar_a;
      bus.m_r_ready = tbl[i].r_rdy;
      #2;
      chk($sformatf("rd%0d_grant", i), 32'(bus.rd_grant), 32'(tbl[i].gnt));
      chk($sformatf("rd%0d_s_ar_valid", i), 32'(bus.s_ar_valid), 32'(tbl[i].s_arv));
      chk($sformatf("rd%0d_m_ar_ready", i), 32'(bus.m_ar_ready), 32'(tbl[i].ar_rdy));
      chk($sformatf("rd%0d_m_r_valid", i), 32'(bus.m_r_valid), 32'(tbl[i].r_v));
      chk($sformatf("rd%0d_s_r_ready", i), 32'(bus.s_r_ready), 32'(tbl[i].s_rrdy));
      if (tbl[i].s_arv) chk($sformatf("rd%0d_s_ar_addr", i), 32'(bus.s_ar_addr), 32'(tbl[i].s_ara));
      if (|tbl[i].r_v) chk($sformatf("rd%0d_r_data", i), bus.m_r_data, tbl[i].r_d);
      step();
    end
    w0 = w_cnt;
    bus.s_aw_ready = 1'b0;
    bus.m_w_valid = 2'b01;
    bus.m_w_data = 64'h5;
    #2 chk("wr_w_only_s_w_valid", 32'(bus.s_w_valid), 0);
    chk("wr_w_only_m_w_ready", 32'(bus.m_w_ready), 0);
    step();
    #2 chk("wr_w_only2_grant", 32'(bus.wr_grant), 0);
    step();
    bus.m_aw_valid = 2'b01;
    bus.m_aw_addr = 8'h03;
    #2 chk("wr_idle_s_aw_valid", 32'(bus.s_aw_valid), 0);
    step();
    #2 chk("wr_req_grant", 32'(bus.wr_grant), 32'h1);
    chk("wr_req_s_aw_valid", 32'(bus.s_aw_valid), 1);
    chk("wr_req_s_aw_addr", 32'(bus.s_aw_addr), 32'h3);
    chk("wr_req_s_w_valid", 32'(bus.s_w_valid), 1);
    chk("wr_req_s_w_data", bus.s_w_data, 32'h5);
    chk("wr_req_m_w_ready", 32'(bus.m_w_ready), 32'h1);
    chk("wr_req_m_aw_ready", 32'(bus.m_aw_ready), 0);
    step();
    bus.m_w_valid = 2'b00;
    #2 chk("wr_wdone_s_w_valid", 32'(bus.s_w_valid), 0);
    chk("wr_wdone_s_aw_valid", 32'(bus.s_aw_valid), 1);
    chk("wr_wdone_m_b_valid", 32'(bus.m_b_valid), 0);
    step();
    bus.s_aw_ready = 1'b1;
    #2 chk("wr_aw_m_aw_ready", 32'(bus.m_aw_ready), 32'h1);
    step();
    bus.m_aw_valid = 2'b00;
    #2 chk("wr_resp_m_b_valid", 32'(bus.m_b_valid), 32'h1);
    chk("wr_resp_s_b_ready", 32'(bus.s_b_ready), 1);
    chk("wr_resp_grant", 32'(bus.wr_grant), 32'h1);
    step();
    #2 chk("wr_done_grant", 32'(bus.wr_grant), 0);
    chk("wr_done_m_b_valid", 32'(bus.m_b_valid), 0);
    chk("wr_w_hs_count", 32'(w_cnt - w0), 1);
    chk("wr_slave_addr", 32'(last_aw), 32'h3);
    chk("wr_slave_data", last_w, 32'h5);
    bus.m_aw_valid = 2'b01; bus.m_aw_addr = 8'h02;
    bus.m_w_valid = 2'b01; bus.m_w_data = 64'h22;
    bus.m_ar_valid = 2'b10; bus.m_ar_addr = 8'h70;
    #2 chk("cc_idle_grants", 32'({bus.rd_grant, bus.wr_grant}), 0);
    step();
    #2 chk("cc_rd_grant", 32'(bus.rd_grant), 32'h2);
    chk("cc_wr_grant", 32'(bus.wr_grant), 32'h1);
    chk("cc_s_ar_addr", 32'(bus.s_ar_addr), 32'h7);
    chk("cc_s_aw_addr", 32'(bus.s_aw_addr), 32'h2);
    chk("cc_s_w_data", bus.s_w_data, 32'h22);
    chk("cc_valids", 32'({bus.s_ar_valid, bus.s_aw_valid, bus.s_w_valid}), 32'h7);
    step();
    bus.m_aw_valid = '0; bus.m_w_valid = '0; bus.m_ar_valid = '0;
    #2 chk("cc_m_r_valid", 32'(bus.m_r_valid), 32'h2);
    chk("cc_r_data", bus.m_r_data, 32'hC0DE0007);
    chk("cc_m_b_valid", 32'(bus.m_b_valid), 32'h1);
    step();
    #2 chk("cc_done_grants", 32'({bus.rd_grant, bus.wr_grant}), 0);
    chk("cc_slave_wdata", last_w, 32'h22);
    bus.m_ar_valid = 2'b01; bus.m_ar_addr = 8'h01; bus.m_r_ready = 2'b00;
    step();
    step();
    bus.m_ar_valid = 2'b00;
    #2 chk("rst_pre_m_r_valid", 32'(bus.m_r_valid), 32'h1);
    rst = 1'b1;
    #1 chk("rst_async_outputs", outs(), 32'h0);
    bus.m_ar_valid = 2'b11; bus.m_ar_addr = 8'h21; bus.m_r_ready = 2'b11;
    step();
    rst = 1'b0;
    #2 chk("rst_idle_grant", 32'(bus.rd_grant), 0);
    step();
    #2 chk("rst_rearb_grant", 32'(bus.rd_grant), 32'h1);
    chk("rst_rearb_addr", 32'(bus.s_ar_addr), 32'h1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
